dsm2_bitstream_tx: RTL

//  Second-order digital delta-sigma modulator: turns parallel unsigned samples into a 1-bit stream.
//  It is the transmit end of the bitstream link; its output feeds a CIC2 decimator directly.

---
 rtl/dsm2_bitstream_tx_if.sv | 21 ++
 rtl/dsm2_bitstream_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dsm2_bitstream_tx_if.sv
// Sample handshake between the sample source and the delta-sigma transmitter.
// The source drives sample/valid; the transmitter answers with ready.
interface dsm2_bitstream_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_valid_i;
    logic                  sample_ready_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        input  sample_ready_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output sample_ready_o
    );
endinterface

// File: rtl/dsm2_bitstream_tx.sv
// Second-order delta-sigma modulator: unsigned parallel samples in, 1-bit stream out.
// A one-entry buffer decouples the handshake from the tick-driven zero-order hold.
// Optional feature macro: DSM2_DITHER_EN adds a 1-LSB LFSR dither to the first integrator.
module dsm2_bitstream_tx #(
    parameter int DATA_WIDTH    = 16,
    parameter int INTERP_FACTOR = 10,
    parameter int ACC_WIDTH     = DATA_WIDTH + 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    dsm2_bitstream_tx_if.slave smp,
    output logic               bitstream_o,
    output logic               sample_tick_o,
    output logic               underrun_o,
    input  logic               underrun_clr_i
);
    localparam int CNT_WIDTH = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(INTERP_FACTOR - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] FB_FULL =
        {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, 1'b1, {DATA_WIDTH{1'b0}}};

    logic [CNT_WIDTH-1:0]        tick_cnt;
    logic [DATA_WIDTH-1:0]       buf_q;
    logic [DATA_WIDTH-1:0]       x_q;
    logic                        buf_full;
    logic                        buf_full_next;
    logic                        ready_q;
    logic signed [ACC_WIDTH-1:0] i1_q;
    logic signed [ACC_WIDTH-1:0] i2_q;
    logic                        bit_q;
    logic                        tick_q;
    logic                        underrun_q;
    logic                        accept;
    logic                        tick;
    logic                        load_x;
    logic signed [ACC_WIDTH:0]   x_ext;
    logic signed [ACC_WIDTH:0]   fb_ext;
    logic signed [ACC_WIDTH:0]   i1_ext;
    logic signed [ACC_WIDTH:0]   i2_ext;
    logic signed [ACC_WIDTH:0]   dith_ext;
    logic signed [ACC_WIDTH:0]   sum1;
    logic signed [ACC_WIDTH:0]   sum2;
    logic signed [ACC_WIDTH-1:0] i1_next;
    logic signed [ACC_WIDTH-1:0] i2_next;

    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] v);
        if (v > SAT_MAX) return SAT_MAX[ACC_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[ACC_WIDTH-1:0];
        return v[ACC_WIDTH-1:0];
    endfunction

    assign accept        = smp.sample_valid_i & ready_q;
    assign tick          = enable_i & (tick_cnt == CNT_LAST);
    assign load_x        = tick & buf_full;
    assign buf_full_next = accept | (buf_full & ~tick);

    assign smp.sample_ready_o = ready_q;
    assign bitstream_o        = bit_q;
    assign sample_tick_o      = tick_q;
    assign underrun_o         = underrun_q;

`ifdef DSM2_DITHER_EN
    logic [15:0] lfsr_q;

    // Maximal-length LFSR whose LSB nudges the first integrator to break idle tones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else if (enable_i) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign dith_ext = {{ACC_WIDTH{1'b0}}, lfsr_q[0]};
`else
    assign dith_ext = '0;
`endif

    // Integrator sums in one extra bit so the clamp sees the true overflow
    always_comb begin
        x_ext   = {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, x_q};
        fb_ext  = bit_q ? FB_FULL : '0;
        i1_ext  = {i1_q[ACC_WIDTH-1], i1_q};
        i2_ext  = {i2_q[ACC_WIDTH-1], i2_q};
        sum1    = i1_ext + x_ext + dith_ext - fb_ext;
        sum2    = i2_ext + i1_ext - fb_ext;
        i1_next = sat(sum1);
        i2_next = sat(sum2);
    end

    // One-entry buffer; ready mirrors "buffer empty" one clock late, so it rises after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q    <= '0;
            buf_full <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            if (accept) buf_q <= smp.sample_i;
            buf_full <= buf_full_next;
            ready_q  <= ~buf_full_next;
        end
    end

    // Bit-period counter that paces sample consumption
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
        end else if (enable_i) begin
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    // Zero-order hold plus the two integrators and the quantiser bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q   <= '0;
            i1_q  <= '0;
            i2_q  <= '0;
            bit_q <= 1'b0;
        end else if (enable_i) begin
            if (load_x) x_q <= buf_q;
            i1_q  <= i1_next;
            i2_q  <= i2_next;
            bit_q <= ~i2_next[ACC_WIDTH-1] & (|i2_next);
        end
    end

    // Status: load pulse and sticky underrun, where a new underrun beats the clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            tick_q <= load_x;
            if (tick & ~buf_full) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr_i) begin
                underrun_q <= 1'b0;
            end
        end
    end
endmodule
